// File: rtl/pipeline_ex_muldiv_ctrl.sv
// EX-stage sequencer for RV64M multiply/divide. Holds the pipeline via stall_EX while an
// iterative shift-add multiplier or restoring divider runs, then strobes a registered result.
module pipeline_ex_muldiv_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall_EX,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned HALF = XLEN / 2;
  localparam int unsigned W2   = 2 * XLEN;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]   acc_q, acc_d;     // product, or remainder in the low XLEN bits
  logic [XLEN-1:0] opa_q, opa_d;     // multiplier, or dividend/quotient shift register
  logic [W2-1:0]   opb_q, opb_d;     // shifting multiplicand, or divisor in the low XLEN bits
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            neg_q, neg_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  // Operand decode at issue time. Word MULH* variants collapse onto MUL.
  logic [2:0]      op_eff;
  logic            s1_sgn, s2_sgn, neg_a, neg_b, div_zero, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, dvd_sext, early_res;

  assign op_eff   = (word && !op[2]) ? 3'b000 : op;
  assign s1_sgn   = op_eff[2] ? !op_eff[0] : (op_eff != 3'b011);
  assign s2_sgn   = op_eff[2] ? !op_eff[0] : !op_eff[1];
  assign a_ext    = word ? {{HALF{s1_sgn & src1[HALF-1]}}, src1[HALF-1:0]} : src1;
  assign b_ext    = word ? {{HALF{s2_sgn & src2[HALF-1]}}, src2[HALF-1:0]} : src2;
  assign neg_a    = s1_sgn & a_ext[XLEN-1];
  assign neg_b    = s2_sgn & b_ext[XLEN-1];
  assign a_mag    = neg_a ? -a_ext : a_ext;
  assign b_mag    = neg_b ? -b_ext : b_ext;
  assign dvd_sext = word ? {{HALF{src1[HALF-1]}}, src1[HALF-1:0]} : src1;
  assign div_zero = op_eff[2] && (b_ext == '0);
  // Most-negative / -1 for signed divide; all-ones b_ext covers the word case too.
  assign ovf      = op_eff[2] && !op_eff[0] && (b_ext == '1) &&
                    (word ? (src1[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}})
                          : (src1 == {1'b1, {(XLEN-1){1'b0}}}));
  assign early_res = div_zero ? (op_eff[1] ? dvd_sext : '1)
                              : (op_eff[1] ? '0 : dvd_sext);

  // One iteration of the datapath plus final sign correction / result selection.
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [W2-1:0]   acc_step, opb_step, prod_c;
  logic [XLEN-1:0] opa_step, mul_sel, div_raw, div_c, res_raw, fin_res;

  always_comb begin
    rem_sh   = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
    ge       = rem_sh >= {1'b0, opb_q[XLEN-1:0]};
    acc_step = acc_q;
    opa_step = opa_q;
    opb_step = opb_q;
    if (op_q[2]) begin
      acc_step = {{XLEN{1'b0}}, ge ? (rem_sh[XLEN-1:0] - opb_q[XLEN-1:0]) : rem_sh[XLEN-1:0]};
      opa_step = {opa_q[XLEN-2:0], ge};
    end else begin
      acc_step = acc_q + (opa_q[0] ? opb_q : '0);
      opa_step = opa_q >> 1;
      opb_step = opb_q << 1;
    end
    prod_c  = neg_q ? -acc_step : acc_step;
    mul_sel = (op_q == 3'b000) ? prod_c[XLEN-1:0] : prod_c[W2-1:XLEN];
    div_raw = op_q[1] ? acc_step[XLEN-1:0] : opa_step;
    div_c   = neg_q ? -div_raw : div_raw;
    res_raw = op_q[2] ? div_c : mul_sel;
    fin_res = word_q ? {{HALF{res_raw[HALF-1]}}, res_raw[HALF-1:0]} : res_raw;
  end

  // Next-state: issue, iterate, retire; flush always returns to IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d   = op_eff;
          word_d = word;
          rd_d   = rd_in;
          neg_d  = (op_eff[2] && op_eff[1]) ? neg_a : (neg_a ^ neg_b);
          if (div_zero || ovf) begin
            state_d  = DONE;
            result_d = early_res;
            rd_out_d = rd_in;
          end else begin
            state_d = CALC;
            cnt_d   = word ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
            acc_d   = '0;
            // Word divides pre-align the dividend so its MSB shifts out first.
            opa_d   = (op_eff[2] && word) ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
            opb_d   = {{XLEN{1'b0}}, b_mag};
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          opa_d = opa_step;
          opb_d = opb_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = fin_res;
            rd_out_d = rd_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign stall_EX     = reset && !flush && (((state_q == IDLE) && start) || (state_q == CALC));
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE) && !flush;
  assign result       = result_q;
  assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_pipeline_ex_muldiv_ctrl.sv
// Randomized + directed bench for pipeline_ex_muldiv_ctrl with a queue scoreboard.
module tb_pipeline_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic        word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        stall_EX, busy, result_valid;
  logic [63:0] result;
  logic [4:0]  rd_out;

  pipeline_ex_muldiv_ctrl #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .word(word), .src1(src1), .src2(src2),
    .rd_in(rd_in), .flush(flush), .stall_EX(stall_EX), .busy(busy),
    .result_valid(result_valid), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [2:0]  o;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
  } vec_t;
  vec_t dv[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
  endtask

  // Reference model: RISC-V M semantics from plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ps;
    logic [127:0]        pu;
    logic signed [63:0]  sa, sb64;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         r32;
    logic [63:0]         r;
    sa = a; sb64 = b; sa32 = a[31:0]; sb32 = b[31:0];
    if (w) begin
      if (o == 3'd4) begin
        if (b[31:0] == 0) r32 = 32'hFFFF_FFFF;
        else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
        else r32 = sa32 / sb32;
      end else if (o == 3'd5) begin
        r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
      end else if (o == 3'd6) begin
        if (b[31:0] == 0) r32 = a[31:0];
        else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = 32'd0;
        else r32 = sa32 % sb32;
      end else if (o == 3'd7) begin
        r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
      end else begin
        r32 = a[31:0] * b[31:0];
      end
      return {{32{r32[31]}}, r32};
    end
    case (o)
      3'd0: r = a * b;
      3'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
      3'd2: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = ps[127:64]; end
      3'd3: begin pu = {64'd0, a} * {64'd0, b}; r = pu[127:64]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
        else r = sa / sb64;
      end
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
        else r = sa % sb64;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one op, hold start while stalled (as the pipeline would), push the expectation.
  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res);
    logic [4:0] rd;
    int         lat, stalls;
    bit         early;
    exp_t       e;
    rd    = 5'($urandom);
    early = o[2] && ((w ? (b[31:0] == 0) : (b == 0)) ||
            (!o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == '1))));
    lat   = early ? 1 : (w ? 33 : 65);
    @(posedge clk); #1;
    start = 1'b1; op = o; word = w; src1 = a; src2 = b; rd_in = rd; flush = 1'b0;
    e.res = exp_res; e.rd = rd; e.cyc = cyc + lat;
    sb.push_back(e);
    stalls = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall_EX) break;
      stalls++;
    end
    check("stall_cycles", 64'(stalls), 64'(lat));
    check("busy_in_done", 64'(busy), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor: every result strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset && result_valid) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: result_valid=1 result=0x%h, expected no strobe", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("rd_out", 64'(rd_out), 64'(mon_e.rd));
        check("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  o;
    logic        w;
    logic [63:0] a, b;
    logic [63:0] m;

    dv.push_back('{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB});
    dv.push_back('{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1});
    dv.push_back('{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    dv.push_back('{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    dv.push_back('{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD});
    dv.push_back('{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    dv.push_back('{3'd5, 1'b0, 64'd100, 64'd7, 64'd14});
    dv.push_back('{3'd7, 1'b0, 64'd100, 64'd7, 64'd2});
    dv.push_back('{3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    dv.push_back('{3'd6, 1'b0, 64'd5, 64'd0, 64'd5});
    dv.push_back('{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'h8000_0000_0000_0000});
    dv.push_back('{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
    dv.push_back('{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE});
    dv.push_back('{3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 64'd0);
    check("reset_rd_out", 64'(rd_out), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(result_valid), 64'd0);
    reset = 1'b1;

    foreach (dv[i]) issue(dv[i].o, dv[i].w, dv[i].a, dv[i].b, dv[i].e);

    // Flush at CALC cycle 10
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; word = 1'b0; src1 = {$urandom, $urandom}; src2 = 64'd3;
    rd_in = 5'd9;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall_drop", 64'(stall_EX), 64'd0);
    check("flush_valid", 64'(result_valid), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    issue(3'd5, 1'b0, 64'd100, 64'd7, 64'd14);

    // Flush coincident with DONE of an early-out op
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; word = 1'b0; src1 = 64'd5; src2 = 64'd0; rd_in = 5'd3;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_valid", 64'(result_valid), 64'd0);
    check("flush_done_stall", 64'(stall_EX), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_done_busy", 64'(busy), 64'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = w ? {b[63:32], 32'd0} : 64'd0;
        1: begin
          if (w) begin
            a = {a[63:32], 32'h8000_0000}; b = {b[63:32], 32'hFFFF_FFFF};
          end else begin
            a = 64'h8000_0000_0000_0000; b = '1;
          end
        end
        2: begin
          m = 64'($urandom_range(0, 1000)); a = $urandom_range(0, 1) ? -m : m;
          m = 64'($urandom_range(1, 50));   b = $urandom_range(0, 1) ? -m : m;
        end
        default: ;
      endcase
      issue(o, w, a, b, ref_model(o, w, a, b));
    end

    // Reset pulsed mid-CALC aborts with all outputs cleared
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; word = 1'b0; src1 = 64'd12345; src2 = 64'd678; rd_in = 5'd17;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_result", result, 64'd0);
    check("rst_rd_out", 64'(rd_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall_EX), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    issue(3'd7, 1'b0, 64'd100, 64'd7, 64'd2);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
